// File: rtl/ballot_pkg.sv
// Shared types and constants for the ballot input conditioner: FSM state
// encoding, reject reason codes, one-hot candidate values and helpers.
package ballot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECTED = 3'd1,
        ST_COMMIT   = 3'd2,
        ST_RELEASE  = 3'd3,
        ST_LOCKED   = 3'd4
    } state_e;

    localparam logic [1:0] REJ_NONE    = 2'd0;
    localparam logic [1:0] REJ_MULTI   = 2'd1;
    localparam logic [1:0] REJ_NOSEL   = 2'd2;
    localparam logic [1:0] REJ_TIMEOUT = 2'd3;

    localparam logic [3:0] CAND0 = 4'b0001;
    localparam logic [3:0] CAND1 = 4'b0010;
    localparam logic [3:0] CAND2 = 4'b0100;
    localparam logic [3:0] CAND3 = 4'b1000;

    function automatic logic is_onehot4(input logic [3:0] v);
        case (v)
            CAND0, CAND1, CAND2, CAND3: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    // True when two or more candidate buttons are pressed together.
    function automatic logic is_multi4(input logic [3:0] v);
        return (v & (v - 4'b0001)) != 4'b0000;
    endfunction

endpackage

// File: rtl/ballot_input_conditioner_if.sv
// Raw button inputs and conditioned ballot outputs of the conditioner.
// slave = the conditioner itself, master = whatever drives the buttons.
interface ballot_input_conditioner_if;
    logic [3:0] btn_raw;
    logic       confirm_raw;
    logic       enable;
    logic       unlock;
    logic [3:0] voter_out;
    logic       confirm_out;
    logic       reject_pulse;
    logic [1:0] reject_code;
    logic       busy;
    logic [2:0] state_dbg;

    modport slave (
        input  btn_raw, confirm_raw, enable, unlock,
        output voter_out, confirm_out, reject_pulse, reject_code, busy, state_dbg
    );

    modport master (
        output btn_raw, confirm_raw, enable, unlock,
        input  voter_out, confirm_out, reject_pulse, reject_code, busy, state_dbg
    );
endinterface

// File: rtl/ballot_input_conditioner_input_debouncer.sv
// One button bit: 2-flop synchroniser followed by a counter that flips the
// debounced level after DEBOUNCE_CYCLES consecutive disagreeing samples.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             r_meta;
    logic             r_sync;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    // Synchronise the raw bit and count how long it has disagreed with the level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            if (r_sync == r_level) begin
                r_cnt <= {CNT_W{1'b0}};
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_level <= r_sync;
                r_cnt   <= {CNT_W{1'b0}};
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/ballot_input_conditioner.sv
// Conditions four candidate buttons and a confirm button into a one-hot
// selection plus a single confirm strobe per ballot. Optional macro
// BALLOT_SESSION_LOCK_EN holds the machine in LOCKED after each vote until unlock.
module ballot_input_conditioner
    import ballot_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    ballot_input_conditioner_if.slave   io
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    logic [4:0]       w_raw;
    logic [4:0]       w_deb;
    logic [3:0]       w_btn;
    logic             w_conf;
    logic             w_multi;

    state_e           r_state;
    logic [3:0]       r_voter;
    logic             r_confirm;
    logic             r_reject;
    logic [1:0]       r_code;
    logic             r_busy;
    logic [TMR_W-1:0] r_timer;

    assign w_raw = {io.confirm_raw, io.btn_raw};

    for (genvar g = 0; g < 5; g++) begin : g_deb
        input_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk     (clk),
            .rst     (rst),
            .i_raw   (w_raw[g]),
            .o_level (w_deb[g])
        );
    end

    assign w_btn   = w_deb[3:0];
    assign w_conf  = w_deb[4];
    assign w_multi = is_multi4(w_btn);

`ifndef BALLOT_SESSION_LOCK_EN
    logic w_unused_unlock;
    assign w_unused_unlock = io.unlock;
`endif

    // Ballot FSM: state and every output are updated together on each edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_voter   <= 4'b0000;
            r_confirm <= 1'b0;
            r_reject  <= 1'b0;
            r_code    <= REJ_NONE;
            r_busy    <= 1'b0;
            r_timer   <= {TMR_W{1'b0}};
        end else begin
            r_confirm <= 1'b0;
            r_reject  <= 1'b0;
            if (!io.enable) begin
                r_state <= ST_IDLE;
                r_voter <= 4'b0000;
                r_busy  <= 1'b0;
                r_timer <= {TMR_W{1'b0}};
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_multi) begin
                            r_reject <= 1'b1;
                            r_code   <= REJ_MULTI;
                            r_state  <= ST_RELEASE;
                            r_busy   <= 1'b1;
                        end else if (w_conf && (w_btn == 4'b0000)) begin
                            r_reject <= 1'b1;
                            r_code   <= REJ_NOSEL;
                            r_state  <= ST_RELEASE;
                            r_busy   <= 1'b1;
                        end else if (is_onehot4(w_btn) && !w_conf) begin
                            r_state <= ST_SELECTED;
                            r_voter <= w_btn;
                            r_busy  <= 1'b1;
                            r_timer <= {TMR_W{1'b0}};
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    ST_SELECTED: begin
                        // Confirm outranks any simultaneous change, so the held choice commits
                        if (w_conf) begin
                            r_state   <= ST_COMMIT;
                            r_confirm <= 1'b1;
                        end else if (w_multi) begin
                            r_reject <= 1'b1;
                            r_code   <= REJ_MULTI;
                            r_state  <= ST_RELEASE;
                            r_voter  <= 4'b0000;
                        end else if (is_onehot4(w_btn) && (w_btn != r_voter)) begin
                            r_voter <= w_btn;
                            r_timer <= {TMR_W{1'b0}};
                        end else if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                            r_reject <= 1'b1;
                            r_code   <= REJ_TIMEOUT;
                            r_state  <= ST_RELEASE;
                            r_voter  <= 4'b0000;
                        end else begin
                            r_timer <= r_timer + TMR_W'(1);
                        end
                    end
                    ST_COMMIT: begin
                        r_voter <= 4'b0000;
`ifdef BALLOT_SESSION_LOCK_EN
                        r_state <= ST_LOCKED;
`else
                        r_state <= ST_RELEASE;
`endif
                    end
                    ST_RELEASE: begin
                        r_voter <= 4'b0000;
                        if (w_deb == 5'b00000) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_RELEASE;
                        end
                    end
`ifdef BALLOT_SESSION_LOCK_EN
                    ST_LOCKED: begin
                        r_voter <= 4'b0000;
                        if (io.unlock) begin
                            r_state <= ST_RELEASE;
                        end else begin
                            r_state <= ST_LOCKED;
                        end
                    end
`endif
                    default: begin
                        r_state <= ST_IDLE;
                        r_voter <= 4'b0000;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign io.voter_out    = r_voter;
    assign io.confirm_out  = r_confirm;
    assign io.reject_pulse = r_reject;
    assign io.reject_code  = r_code;
    assign io.busy         = r_busy;
    assign io.state_dbg    = r_state;

endmodule
